fpu_res_drain: RTL

- Downstream neighbour of the FPU input flip/retime buffer.
- Consumes the buffer's data strobe and data, and grants further output by driving that buffer's `dout_en`.
- Queues results in a small circular FIFO and presents them to the writeback bus with a valid/ready handshake.
- Supports a pipeline flush that discards queued results and blocks upstream until the flush completes.

---
 rtl/fpu_res_drain_pkg.sv | 10 +
 rtl/fpu_res_fifo_mem.sv | 20 ++
 rtl/fpu_res_drain.sv | 74 +++++++
 3 files changed

// File: rtl/fpu_res_drain_pkg.sv
// fpu_res_drain_pkg: shared state encoding and FPU result-path defaults.
package fpu_res_drain_pkg;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH      = 2'd1,
        FLUSH_WAIT = 2'd2
    } state_t;
    localparam int FPU_WIDTH = 32;
    localparam int FPU_DEPTH = 4;
endpackage

// File: rtl/fpu_res_fifo_mem.sv
// fpu_res_fifo_mem: DEPTH x DW register array, one write port, asynchronous read port.
module fpu_res_fifo_mem
    import fpu_res_drain_pkg::*;
#(
    parameter int DEPTH = FPU_DEPTH,
    parameter int DW = FPU_WIDTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fpu_res_drain.sv
// fpu_res_drain: result FIFO between the FPU retime buffer and writeback, with flush.
// FPU_RES_DRAIN_PARITY_EN adds a stored even-parity bit per entry and the par_err output.
module fpu_res_drain
    import fpu_res_drain_pkg::*;
#(
    parameter int WIDTH = FPU_WIDTH,
    parameter int DEPTH = FPU_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             do_,
    input  logic [WIDTH-1:0] d_in,
    output logic             dout_en,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_data,
    input  logic             wb_ready,
    input  logic             flush,
    output logic             flush_done,
    output logic [AW:0]      occ
`ifdef FPU_RES_DRAIN_PARITY_EN
    ,
    output logic             par_err
`endif
);
`ifdef FPU_RES_DRAIN_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    state_t state, state_next;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] occ_next;
    logic fl, wr, rd;
    logic [WIDTH+PW-1:0] wdata, rdata;
    // A flush request takes effect on the edge that enters FLUSH, discarding that cycle's write.
    assign fl = state == RUN && flush;
    assign wr = do_ && dout_en && state == RUN && !flush;
    assign wb_valid = occ != '0 && state == RUN;
    assign rd = wb_valid && wb_ready;
    assign wb_data = rdata[WIDTH-1:0];
    assign occ_next = fl ? '0 : occ + (AW+1)'(wr) - (AW+1)'(rd);
    assign state_next = state == RUN ? (flush ? FLUSH : RUN) : state == FLUSH ? FLUSH_WAIT : RUN;
`ifdef FPU_RES_DRAIN_PARITY_EN
    assign wdata = {^d_in, d_in};
`else
    assign wdata = d_in;
`endif
    fpu_res_fifo_mem #(.DEPTH(DEPTH), .DW(WIDTH+PW)) u_mem (
        .clk(clk), .we(wr), .waddr(wr_ptr), .wdata(wdata), .raddr(rd_ptr), .rdata(rdata)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ <= '0;
            dout_en <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state <= state_next;
            rd_ptr <= fl ? '0 : rd_ptr + AW'(rd);
            wr_ptr <= fl ? '0 : wr_ptr + AW'(wr);
            occ <= occ_next;
            dout_en <= state_next == RUN && occ_next < (AW+1)'(DEPTH);
            flush_done <= state_next == FLUSH_WAIT;
        end
    end
`ifdef FPU_RES_DRAIN_PARITY_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) par_err <= 1'b0;
        else par_err <= rd && !fl && (rdata[WIDTH] != ^rdata[WIDTH-1:0]);
`endif
endmodule
